// File: rtl/dmem_word_arbiter.sv
// dmem_word_arbiter: round-robin arbiter sequencing 32-bit CPU/ext word accesses as four big-endian byte accesses.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module dmem_word_arbiter #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [31:0]   cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_gnt,
  output logic          ext_done,
  output logic [31:0]   ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, XFER, FIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic          own_q, own_d, we_q, we_d, last_q, last_d, pick_ext;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d, cpu_rd_q, cpu_rd_d, ext_rd_q, ext_rd_d;
  logic [23:0]   asm_q, asm_d;
  // own/last encoding: 0 = CPU, 1 = ext
`ifdef DMEM_ARB_CPU_PRIO_EN
  assign pick_ext = ext_req && !cpu_req;
`else
  assign pick_ext = ext_req && (!cpu_req || !last_q);
`endif
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    own_d     = own_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_d     = asm_q;
    cpu_rd_d  = cpu_rd_q;
    ext_rd_d  = ext_rd_q;
    last_d    = last_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == IDLE && (cpu_req || ext_req)) begin
      state_d = XFER;
      k_d     = 2'd0;
      own_d   = pick_ext;
      last_d  = pick_ext;
      we_d    = pick_ext ? ext_we : cpu_we;
      addr_d  = pick_ext ? ext_addr : cpu_addr;
      wdata_d = pick_ext ? ext_wdata : cpu_wdata;
    end
    if (state_q == XFER) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q + AW'(k_q);
      mem_wdata = wdata_q[8*(3-int'(k_q)) +: 8];
      // read data lags the strobe by one cycle, so byte k-1 arrives now
      if (!we_q && k_q != 2'd0) asm_d[8*(3-int'(k_q)) +: 8] = mem_rdata;
      k_d       = k_q + 2'd1;
      state_d   = (k_q == 2'd3) ? FIN : XFER;
    end
    if (state_q == FIN) begin
      if (!we_q && own_q) ext_rd_d = {asm_q, mem_rdata};
      if (!we_q && !own_q) cpu_rd_d = {asm_q, mem_rdata};
      state_d = DONE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      cpu_rd_q <= '0;
      ext_rd_q <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      asm_q    <= asm_d;
      cpu_rd_q <= cpu_rd_d;
      ext_rd_q <= ext_rd_d;
      last_q   <= last_d;
    end
  end
  assign cpu_gnt   = state_q == XFER && k_q == 2'd0 && !own_q;
  assign ext_gnt   = state_q == XFER && k_q == 2'd0 && own_q;
  assign cpu_done  = state_q == DONE && !own_q;
  assign ext_done  = state_q == DONE && own_q;
  assign cpu_rdata = cpu_rd_q;
  assign ext_rdata = ext_rd_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_dmem_word_arbiter.sv
// tb_dmem_word_arbiter: directed checks of word sequencing, arbitration and mid-access reset.
module tb_dmem_word_arbiter;
  localparam int AW = 5;
  logic          clk = 1'b0, rst = 1'b1;
  logic          cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
  logic [31:0]   cpu_wdata = '0, ext_wdata = '0;
  logic          cpu_gnt, cpu_done, ext_gnt, ext_done, mem_en, mem_we, busy;
  logic [31:0]   cpu_rdata, ext_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic [7:0]    mem [32] = '{default: 8'h00};
  int            n_checks = 0, n_fail = 0;

  dmem_word_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic issue(input bit is_ext, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    if (is_ext) begin
      ext_req = 1; ext_we = we; ext_addr = a; ext_wdata = d;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, mem_en, mem_we, cpu_gnt, cpu_done, ext_gnt, ext_done} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0000000", {busy, mem_en, mem_we, cpu_gnt, cpu_done, ext_gnt, ext_done});
    end
    n_checks++;
    if ({cpu_rdata, ext_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata got %h exp 0", {cpu_rdata, ext_rdata});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_store();
    logic [31:0] d = 32'hDEADBEEF;
    issue(0, 1, 5'd4, d);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_gnt !== (c == 1)) begin n_fail++; $display("FAIL store_gnt c=%0d got %b", c, cpu_gnt); end
      n_checks++;
      if (cpu_done !== (c == 6)) begin n_fail++; $display("FAIL store_done c=%0d got %b", c, cpu_done); end
      n_checks++;
      if (busy !== (c <= 6)) begin n_fail++; $display("FAIL store_busy c=%0d got %b", c, busy); end
      n_checks++;
      if ({ext_gnt, ext_done, ext_rdata} !== 34'd0) begin n_fail++; $display("FAIL store_ext_quiet c=%0d got %h", c, {ext_gnt, ext_done, ext_rdata}); end
      n_checks++;
      if (c <= 4) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'(3 + c), 8'(d >> (8 * (4 - c)))}) begin
          n_fail++; $display("FAIL store_byte c=%0d got en=%b we=%b a=%0d d=%h", c, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end else if (mem_en !== 1'b0) begin
        n_fail++; $display("FAIL store_idle_en c=%0d got %b exp 0", c, mem_en);
      end
      if (c == 2) cpu_req = 0;
    end
    n_checks++;
    if ({mem[4], mem[5], mem[6], mem[7]} !== d) begin n_fail++; $display("FAIL store_mem got %h exp %h", {mem[4], mem[5], mem[6], mem[7]}, d); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_gnt !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_no_regrant c=%0d gnt=%b busy=%b", c, cpu_gnt, busy); end
    end
  endtask

  task automatic test_ext_load();
    issue(1, 0, 5'd4, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ext_gnt, ext_done, cpu_gnt, cpu_done} !== {c == 1, c == 6, 2'b00}) begin
        n_fail++; $display("FAIL load_handshake c=%0d got %b", c, {ext_gnt, ext_done, cpu_gnt, cpu_done});
      end
      if (c <= 4) begin
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 5'(3 + c)}) begin n_fail++; $display("FAIL load_byte c=%0d got en=%b we=%b a=%0d", c, mem_en, mem_we, mem_addr); end
      end
      if (c == 6) begin
        n_checks++;
        if (ext_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_ext_rdata got %h exp deadbeef", ext_rdata); end
      end
      n_checks++;
      if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL load_cpu_rdata c=%0d got %h exp 0", c, cpu_rdata); end
      if (c == 1) ext_req = 0;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d = 32'h11223344;
    logic [4:0]  exp_a [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    issue(0, 1, 5'd30, d);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, exp_a[c-1], 8'(d >> (8 * (4 - c)))}) begin
          n_fail++; $display("FAIL wrap_byte c=%0d got a=%0d d=%h", c, mem_addr, mem_wdata);
        end
      end
      if (c == 1) cpu_req = 0;
    end
    issue(0, 0, 5'd30, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 6) begin
        n_checks++;
        if (cpu_rdata !== d) begin n_fail++; $display("FAIL wrap_load got %h exp %h", cpu_rdata, d); end
        n_checks++;
        if (ext_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_ext_untouched got %h exp deadbeef", ext_rdata); end
      end
      if (c == 1) cpu_req = 0;
    end
  endtask

  task automatic test_reset_mid();
    issue(0, 1, 5'd8, 32'hAABBCCDD);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_addr, mem_wdata} !== {1'b1, 5'd10, 8'hCC}) begin n_fail++; $display("FAIL mid_k2 got a=%0d d=%h", mem_addr, mem_wdata); end
    rst = 1; cpu_req = 0;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_en, cpu_done} !== 3'b000) begin n_fail++; $display("FAIL mid_idle got %b exp 000", {busy, mem_en, cpu_done}); end
    n_checks++;
    if ({cpu_rdata, ext_rdata} !== 64'd0) begin n_fail++; $display("FAIL mid_rdata_clr got %h exp 0", {cpu_rdata, ext_rdata}); end
    n_checks++;
    if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hAABBCC00) begin n_fail++; $display("FAIL mid_mem got %h exp aabbcc00", {mem[8], mem[9], mem[10], mem[11]}); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done c=%0d got %b", c, cpu_done); end
    end
    rst = 0;
    issue(0, 0, 5'd4, 32'h0);
    issue(1, 0, 5'd0, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if ({cpu_gnt, ext_gnt, cpu_done} !== {c == 1, 1'b0, c == 6}) begin
        n_fail++; $display("FAIL mid_regrant c=%0d got %b", c, {cpu_gnt, ext_gnt, cpu_done});
      end
      if (c == 6) begin
        n_checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_reload got %h exp deadbeef", cpu_rdata); end
        ext_req = 0;
      end
      if (c == 1) cpu_req = 0;
    end
  endtask

  task automatic test_round_robin();
    logic ec, ee, dc, de;
    rst = 1;
    repeat (2) @(negedge clk);
    issue(0, 0, 5'd4, 32'h0);
    issue(1, 0, 5'd0, 32'h0);
    rst = 0;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
`ifdef DMEM_ARB_CPU_PRIO_EN
      ec = (c == 1 || c == 8 || c == 15 || c == 22);
      ee = 1'b0;
      dc = (c == 6 || c == 13 || c == 20 || c == 27);
      de = 1'b0;
`else
      ec = (c == 1 || c == 15);
      ee = (c == 8 || c == 22);
      dc = (c == 6 || c == 20);
      de = (c == 13 || c == 27);
`endif
      n_checks++;
      if ({cpu_gnt, ext_gnt, cpu_done, ext_done} !== {ec, ee, dc, de}) begin
        n_fail++; $display("FAIL rr c=%0d got %b exp %b", c, {cpu_gnt, ext_gnt, cpu_done, ext_done}, {ec, ee, dc, de});
      end
    end
    cpu_req = 0; ext_req = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store();
    test_ext_load();
    test_wrap();
    test_reset_mid();
    test_round_robin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
